// File: rtl/run_control_unit.sv
// Run control for the CPU: debounced step button, FREE/STEP/BURST/HOLD modes and a
// single-domain clock enable. Define RUN_CONTROL_BREAKPOINT_EN to add a PC breakpoint.
module run_control_unit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BURST_W         = 8,
  parameter int CNT_W           = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               step_btn_n,
  input  logic [1:0]         mode_sw,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt_req,
  input  logic               count_clr,
`ifdef RUN_CONTROL_BREAKPOINT_EN
  input  logic [31:0]        pc,
  input  logic [31:0]        bp_addr,
  input  logic               bp_enable,
  output logic               bp_hit,
`endif
  output logic               cpu_clk_en,
  output logic [1:0]         state,
  output logic [BURST_W-1:0] burst_left,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               press
);

  localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BURST = 2'b11
  } state_t;

  logic            btn_p0, btn_p1;
  logic [1:0]      mode_p0, mode_p1;
  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  state_t          state_q, state_d;
  logic [BURST_W-1:0] left_q, left_d;
  logic            bp_match;
  logic            stop_req;

  // Stage p0/p1: two-flop synchronisers for the asynchronous button and switches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_p0  <= 1'b1;
      btn_p1  <= 1'b1;
      mode_p0 <= 2'b00;
      mode_p1 <= 2'b00;
    end else begin
      btn_p0  <= step_btn_n;
      btn_p1  <= btn_p0;
      mode_p0 <= mode_sw;
      mode_p1 <= mode_p0;
    end
  end

  // Debounce: the synced level must differ for DEBOUNCE_CYCLES consecutive edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_cnt   <= '0;
      db_level <= 1'b1;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        db_level <= btn_p1;
        press    <= ~btn_p1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

`ifdef RUN_CONTROL_BREAKPOINT_EN
  assign bp_match = bp_enable && (pc == bp_addr) && cpu_clk_en &&
                    ((state_q == S_RUN) || (state_q == S_BURST));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bp_hit <= 1'b0;
    else        bp_hit <= bp_match;
  end
`else
  assign bp_match = 1'b0;
`endif

  assign stop_req = halt_req | bp_match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
    end
  end

  // STEP deliberately ignores halt_req so the CPU can be stepped past a breakpoint
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    case (state_q)
      S_IDLE: begin
        left_d = '0;
        if (mode_p1 == MODE_FREE) begin
          if (!halt_req) state_d = S_RUN;
        end else if (mode_p1 == MODE_STEP) begin
          if (press) state_d = S_STEP;
        end else if (mode_p1 == MODE_BURST) begin
          if (press && !halt_req && (burst_len != '0)) begin
            state_d = S_BURST;
            left_d  = burst_len;
          end
        end
      end
      S_RUN: begin
        if ((mode_p1 != MODE_FREE) || stop_req) state_d = S_IDLE;
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      S_BURST: begin
        if ((mode_p1 != MODE_BURST) || stop_req || (left_q == BURST_W'(1))) begin
          state_d = S_IDLE;
          left_d  = '0;
        end else begin
          left_d = left_q - BURST_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        left_d  = '0;
      end
    endcase
  end

  assign cpu_clk_en = (state_q != S_IDLE);
  assign state      = state_q;
  assign burst_left = left_q;

  // A clear coinciding with an enabled cycle leaves the counter at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          cycle_count <= '0;
    else if (count_clr)  cycle_count <= '0;
    else if (cpu_clk_en) cycle_count <= cycle_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_run_control_unit.sv
// Scoreboard bench for run_control_unit: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops and compares; two instances share stimulus (32-bit and 4-bit counters).
module tb_run_control_unit;

  localparam int D  = 4;
  localparam int BW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          step_btn_n;
  logic [1:0]    mode_sw;
  logic [BW-1:0] burst_len;
  logic          halt_req;
  logic          count_clr;
  logic          cpu_clk_en, press;
  logic [1:0]    state;
  logic [BW-1:0] burst_left;
  logic [31:0]   cycle_count;
  logic          w_en, w_press;
  logic [1:0]    w_state;
  logic [BW-1:0] w_left;
  logic [3:0]    w_count;
`ifdef RUN_CONTROL_BREAKPOINT_EN
  logic [31:0]   pc, bp_addr;
  logic          bp_enable, bp_hit, w_bp_hit;
`endif

  always #5 clock = ~clock;

  run_control_unit #(.DEBOUNCE_CYCLES(D), .BURST_W(BW), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .step_btn_n(step_btn_n), .mode_sw(mode_sw),
    .burst_len(burst_len), .halt_req(halt_req), .count_clr(count_clr),
`ifdef RUN_CONTROL_BREAKPOINT_EN
    .pc(pc), .bp_addr(bp_addr), .bp_enable(bp_enable), .bp_hit(bp_hit),
`endif
    .cpu_clk_en(cpu_clk_en), .state(state), .burst_left(burst_left),
    .cycle_count(cycle_count), .press(press));

  run_control_unit #(.DEBOUNCE_CYCLES(D), .BURST_W(BW), .CNT_W(4)) dut_w (
    .clock(clock), .reset(reset), .step_btn_n(step_btn_n), .mode_sw(mode_sw),
    .burst_len(burst_len), .halt_req(halt_req), .count_clr(count_clr),
`ifdef RUN_CONTROL_BREAKPOINT_EN
    .pc(pc), .bp_addr(bp_addr), .bp_enable(bp_enable), .bp_hit(w_bp_hit),
`endif
    .cpu_clk_en(w_en), .state(w_state), .burst_left(w_left),
    .cycle_count(w_count), .press(w_press));

  typedef struct packed {
    logic [1:0]    st;
    logic          en;
    logic [BW-1:0] left;
    logic [31:0]   cnt;
    logic          prs;
    logic          bp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: 0 IDLE, 1 RUN, 2 STEP, 3 BURST
  int          m_state;
  logic [7:0]  m_left;
  logic [31:0] m_count;
  bit          m_press, m_level, m_bp;
  bit          raw_hist[$];
  logic [1:0]  mode_hist[$];
  bit          win[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_left = 0; m_count = 0;
    m_press = 0; m_level = 1; m_bp = 0;
    raw_hist.delete(); raw_hist.push_back(1'b1); raw_hist.push_back(1'b1);
    mode_hist.delete(); mode_hist.push_back(2'b00); mode_hist.push_back(2'b00);
    win.delete();
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.st = 2'(m_state); e.en = (m_state != 0); e.left = m_left;
    e.cnt = m_count; e.prs = m_press; e.bp = m_bp;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step();
    bit s, np, nb, stop, all_diff;
    logic [1:0] md;
    int ns;
    logic [7:0] nl;
    logic [31:0] nc;
    if (!reset) begin
      model_reset();
      push_exp();
      return;
    end
    s  = raw_hist.pop_front();  raw_hist.push_back(step_btn_n);
    md = mode_hist.pop_front(); mode_hist.push_back(mode_sw);
    nc = count_clr ? 32'd0 : ((m_state != 0) ? m_count + 32'd1 : m_count);
    nb = 0;
`ifdef RUN_CONTROL_BREAKPOINT_EN
    if ((m_state == 1 || m_state == 3) && bp_enable && pc == bp_addr) nb = 1;
`endif
    stop = halt_req || nb;
    ns = m_state; nl = m_left;
    if (m_state == 0) begin
      nl = 0;
      if (md == 2'b00 && !halt_req) ns = 1;
      else if (md == 2'b01 && m_press) ns = 2;
      else if (md == 2'b10 && m_press && !halt_req && burst_len != 0) begin
        ns = 3; nl = burst_len;
      end
    end else if (m_state == 1) begin
      if (md != 2'b00 || stop) ns = 0;
    end else if (m_state == 2) begin
      ns = 0;
    end else begin
      if (md != 2'b10 || stop || m_left == 1) begin ns = 0; nl = 0; end
      else nl = m_left - 8'd1;
    end
    // a new level is accepted once the last D synced samples all disagree with it
    win.push_back(s);
    if (win.size() > D) void'(win.pop_front());
    all_diff = (win.size() == D);
    foreach (win[i]) if (win[i] == m_level) all_diff = 0;
    np = 0;
    if (all_diff) begin
      m_level = s; np = !s; win.delete();
    end
    m_state = ns; m_left = nl; m_count = nc; m_press = np; m_bp = nb;
    push_exp();
  endfunction

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state", 32'(state), 32'(mon_e.st));
      chk("cpu_clk_en", 32'(cpu_clk_en), 32'(mon_e.en));
      chk("burst_left", 32'(burst_left), 32'(mon_e.left));
      chk("cycle_count", cycle_count, mon_e.cnt);
      chk("press", 32'(press), 32'(mon_e.prs));
      chk("w_state", 32'(w_state), 32'(mon_e.st));
      chk("w_cpu_clk_en", 32'(w_en), 32'(mon_e.en));
      chk("w_burst_left", 32'(w_left), 32'(mon_e.left));
      chk("w_cycle_count", 32'(w_count), 32'(mon_e.cnt[3:0]));
      chk("w_press", 32'(w_press), 32'(mon_e.prs));
`ifdef RUN_CONTROL_BREAKPOINT_EN
      chk("bp_hit", 32'(bp_hit), 32'(mon_e.bp));
      chk("w_bp_hit", 32'(w_bp_hit), 32'(mon_e.bp));
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_button(input int lo, input int hi);
    step_btn_n = 1'b0; ticks(lo);
    step_btn_n = 1'b1; ticks(hi);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_en"}, 32'(cpu_clk_en), 32'd0);
    chk({tag, "_left"}, 32'(burst_left), 32'd0);
    chk({tag, "_count"}, cycle_count, 32'd0);
    chk({tag, "_press"}, 32'(press), 32'd0);
  endtask

  initial begin
    bit found;
    int lo, hi;
    reset = 1'b0; step_btn_n = 1'b1; mode_sw = 2'b11; burst_len = '0;
    halt_req = 1'b1; count_clr = 1'b0;
`ifdef RUN_CONTROL_BREAKPOINT_EN
    pc = '0; bp_addr = 32'h40; bp_enable = 1'b0;
`endif
    model_reset();
    ticks(3);
    @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    ticks(4);
    halt_req = 1'b0;
    ticks(2);

    // short glitch in STEP mode must not produce a press
    mode_sw = 2'b01; ticks(3);
    push_button(3, 10);
    @(negedge clock);
    chk("glitch_count", cycle_count, 32'd0);
    chk("glitch_state", 32'(state), 32'd0);

    for (int k = 0; k < 3; k++) push_button(20, 20);
    @(negedge clock);
    chk("step_count", cycle_count, 32'd3);

    mode_sw = 2'b10; burst_len = 8'd5; count_clr = 1'b1; tick();
    count_clr = 1'b0; ticks(3);
    push_button(20, 20);
    @(negedge clock);
    chk("burst5_count", cycle_count, 32'd5);
    burst_len = 8'd0;
    push_button(20, 20);
    @(negedge clock);
    chk("burst0_count", cycle_count, 32'd5);

    mode_sw = 2'b00; ticks(4);
    count_clr = 1'b1; tick(); count_clr = 1'b0;
    ticks(17);
    @(negedge clock);
    chk("wrap_count4", 32'(w_count), 32'd1);
    chk("free_count17", cycle_count, 32'd17);
    ticks(83);
    @(negedge clock);
    chk("free_count100", cycle_count, 32'd100);
    halt_req = 1'b1; tick();
    @(negedge clock);
    chk("halt_state", 32'(state), 32'd0);
    halt_req = 1'b0; tick();
    @(negedge clock);
    chk("resume_state", 32'(state), 32'd1);

    // long burst aborted by an asynchronous reset
    mode_sw = 2'b10; burst_len = 8'd200; ticks(4);
    step_btn_n = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      @(negedge clock);
      if (burst_left == 8'd150) found = 1;
    end
    chk("burst150_reached", 32'(found), 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    step_btn_n = 1'b1;
    ticks(3);
    @(negedge clock);
    reset = 1'b1;

    for (int seg = 0; seg < 300; seg++) begin
      mode_sw   = 2'($urandom_range(0, 3));
      halt_req  = ($urandom_range(0, 4) == 0);
      burst_len = 8'($urandom_range(0, 9));
      lo = $urandom_range(1, 10);
      hi = $urandom_range(1, 10);
      step_btn_n = 1'b0;
      for (int i = 0; i < lo; i++) begin count_clr = ($urandom_range(0, 19) == 0); tick(); end
      step_btn_n = 1'b1;
      for (int i = 0; i < hi; i++) begin count_clr = ($urandom_range(0, 19) == 0); tick(); end
    end
    count_clr = 1'b0; halt_req = 1'b0;
    ticks(5);

`ifdef RUN_CONTROL_BREAKPOINT_EN
    mode_sw = 2'b00; bp_enable = 1'b1; bp_addr = 32'h40; pc = '0;
    ticks(4);
    for (int i = 0; i <= 16; i++) begin pc = 32'(i * 4); tick(); end
    @(negedge clock);
    chk("bp_hit_pulse", 32'(bp_hit), 32'd1);
    chk("bp_state", 32'(state), 32'd0);
    bp_enable = 1'b0; pc = '0;
    ticks(5);
`endif

    @(negedge clock);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
